// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and widths for the frame accumulator.
package pipe_pkg;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   localparam int SUM_W = 16;
   localparam int DROP_W = 8;
endpackage

// File: rtl/valid_delay.sv
// valid_delay: LAT-stage valid shift register that lines in_valid up with the upstream result.
module valid_delay #(
   parameter int LAT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic i_valid,
   output logic o_valid
);
   logic [LAT-1:0] r_sr;
   always_ff @(posedge clk) begin
      if (rst) r_sr <= '0;
      else begin
         r_sr[0] <= i_valid;
         for (int k = 1; k < LAT; k++) r_sr[k] <= r_sr[k-1];
      end
   end
   assign o_valid = r_sr[LAT-1];
endmodule

// File: rtl/pipe_frame_acc.sv
// pipe_frame_acc: builds sum/max/min summaries over frames of pipeline results.
module pipe_frame_acc
   import pipe_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LAT = 3,
   parameter int FRAME_LEN = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] pipe_out,
   input  logic              frame_ready,
   output logic              frame_valid,
   output logic [SUM_W-1:0]  sum_out,
   output logic [DATA_W-1:0] max_out,
   output logic [DATA_W-1:0] min_out,
   output logic [DROP_W-1:0] drop_cnt
);
   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
   state_t r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [SUM_W-1:0] r_sum, r_sum_out, w_sum;
   logic [DATA_W-1:0] r_max, r_min, r_max_out, r_min_out, w_max, w_min;
   logic [DROP_W-1:0] r_drop;
   logic w_sample, w_hs, w_start, w_acc, w_last;
   valid_delay #(.LAT(LAT)) u_vd (.clk(clk), .rst(rst), .i_valid(in_valid), .o_valid(w_sample));
   assign w_hs = (r_state == DONE) && frame_ready;
   assign w_start = w_sample && ((r_state == IDLE) || w_hs);
   assign w_acc = w_sample && (r_state == ACCUM);
   assign w_last = w_acc && (r_cnt == LAST);
   assign w_sum = r_sum + SUM_W'(pipe_out);
   assign w_max = (pipe_out > r_max) ? pipe_out : r_max;
   assign w_min = (pipe_out < r_min) ? pipe_out : r_min;
   always_comb begin
      w_next = w_start ? ACCUM : w_last ? DONE : w_hs ? IDLE : r_state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_sum <= '0;
         r_max <= '0;
         r_min <= '0;
         r_sum_out <= '0;
         r_max_out <= '0;
         r_min_out <= '0;
         r_drop <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_sum <= SUM_W'(pipe_out);
            r_max <= pipe_out;
            r_min <= pipe_out;
            r_cnt <= CNT_W'(1);
         end else if (w_acc) begin
            r_sum <= w_sum;
            r_max <= w_max;
            r_min <= w_min;
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_last) begin
            r_sum_out <= w_sum;
            r_max_out <= w_max;
            r_min_out <= w_min;
         end
         // A sample arriving while the summary is still unaccepted has nowhere to go
         if (w_sample && (r_state == DONE) && !frame_ready && (r_drop != '1)) r_drop <= r_drop + 1'b1;
      end
   end
   assign frame_valid = (r_state == DONE);
   assign sum_out = r_sum_out;
   assign max_out = r_max_out;
   assign min_out = r_min_out;
   assign drop_cnt = r_drop;
endmodule

// File: tb/tb_pipe_frame_acc.sv
// tb_pipe_frame_acc: directed checks of framing, backpressure, drops and reset behaviour.
module tb_pipe_frame_acc;
   logic clk = 0, rst = 1, in_valid = 0, frame_ready = 0;
   logic [7:0] d_in = 0, pipe_out;
   logic [7:0] r_dp [3];
   logic frame_valid;
   logic [15:0] sum_out;
   logic [7:0] max_out, min_out, drop_cnt;
   int n_tests = 0, n_fail = 0;
   pipe_frame_acc #(.DATA_W(8), .LAT(3), .FRAME_LEN(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .pipe_out(pipe_out),
      .frame_ready(frame_ready), .frame_valid(frame_valid), .sum_out(sum_out),
      .max_out(max_out), .min_out(min_out), .drop_cnt(drop_cnt)
   );
   always #5 clk = ~clk;
   // Three-stage model of the upstream datapath feeding pipe_out
   always @(posedge clk) begin
      r_dp[0] <= d_in;
      r_dp[1] <= r_dp[0];
      r_dp[2] <= r_dp[1];
   end
   assign pipe_out = r_dp[2];
   task automatic cyc(input logic v, input logic [7:0] d);
      in_valid = v;
      d_in = d;
      @(negedge clk);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0);
   endtask
   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   initial begin
      @(negedge clk);
      idle(2);
      chk("rst_fv", 16'(frame_valid), 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_max", 16'(max_out), 0);
      chk("rst_min", 16'(min_out), 0);
      chk("rst_drop", 16'(drop_cnt), 0);
      rst = 0;
      frame_ready = 1;
      cyc(1, 10); cyc(1, 20); cyc(1, 5); cyc(1, 40);
      idle(2);
      chk("basic_early", 16'(frame_valid), 0);
      idle(1);
      chk("basic_fv", 16'(frame_valid), 1);
      chk("basic_sum", sum_out, 75);
      chk("basic_max", 16'(max_out), 40);
      chk("basic_min", 16'(min_out), 5);
      chk("basic_drop", 16'(drop_cnt), 0);
      idle(1);
      chk("basic_fall", 16'(frame_valid), 0);
      chk("basic_hold", sum_out, 75);
      frame_ready = 0;
      for (int i = 0; i < 6; i++) cyc(1, 255);
      idle(3);
      chk("bp_fv", 16'(frame_valid), 1);
      chk("bp_sum", sum_out, 1020);
      chk("bp_max", 16'(max_out), 255);
      chk("bp_min", 16'(min_out), 255);
      chk("bp_drop", 16'(drop_cnt), 2);
      idle(3);
      chk("bp_fv_hold", 16'(frame_valid), 1);
      chk("bp_sum_hold", sum_out, 1020);
      frame_ready = 1;
      idle(1);
      chk("bp_fall", 16'(frame_valid), 0);
      frame_ready = 0;
      for (int i = 0; i < 4; i++) cyc(1, 1);
      idle(3);
      chk("sim_pre_fv", 16'(frame_valid), 1);
      chk("sim_pre_sum", sum_out, 4);
      cyc(1, 7); cyc(1, 1); cyc(1, 1);
      frame_ready = 1;
      cyc(1, 1);
      chk("sim_hs_fv", 16'(frame_valid), 0);
      frame_ready = 0;
      idle(3);
      chk("sim_fv", 16'(frame_valid), 1);
      chk("sim_sum", sum_out, 10);
      chk("sim_max", 16'(max_out), 7);
      chk("sim_min", 16'(min_out), 1);
      chk("sim_drop", 16'(drop_cnt), 2);
      frame_ready = 1;
      idle(1);
      cyc(1, 50); cyc(1, 60);
      idle(2);
      rst = 1;
      idle(1);
      chk("mid_rst_sum", sum_out, 0);
      chk("mid_rst_drop", 16'(drop_cnt), 0);
      rst = 0;
      for (int i = 0; i < 4; i++) cyc(1, 3);
      idle(2);
      chk("mid_early", 16'(frame_valid), 0);
      idle(1);
      chk("mid_fv", 16'(frame_valid), 1);
      chk("mid_sum", sum_out, 12);
      chk("mid_max", 16'(max_out), 3);
      chk("mid_min", 16'(min_out), 3);
      idle(1);
      chk("mid_fall", 16'(frame_valid), 0);
      cyc(1, 1); idle(1); cyc(1, 2); idle(2); cyc(1, 3); idle(1); cyc(1, 4);
      idle(2);
      chk("gap_early", 16'(frame_valid), 0);
      idle(1);
      chk("gap_fv", 16'(frame_valid), 1);
      chk("gap_sum", sum_out, 10);
      chk("gap_max", 16'(max_out), 4);
      chk("gap_min", 16'(min_out), 1);
      idle(1);
      chk("gap_fall", 16'(frame_valid), 0);
      frame_ready = 0;
      for (int i = 0; i < 304; i++) cyc(1, 9);
      idle(3);
      chk("sat_drop", 16'(drop_cnt), 255);
      chk("sat_sum", sum_out, 36);
      chk("sat_fv", 16'(frame_valid), 1);
      frame_ready = 1;
      idle(1);
      chk("sat_fall", 16'(frame_valid), 0);
      chk("sat_drop_hold", 16'(drop_cnt), 255);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pipe_frame_acc.md
PIPE_FRAME_ACC -- requirements
Module: pipe_frame_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the width of the upstream pipeline result.
REQ-002 SHALL have parameter LAT, default 3, meaning the upstream pipeline latency in cycles, legal range 1..8.
REQ-003 SHALL have parameter FRAME_LEN, default 4, meaning the samples per frame, legal range 2..256.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  in  1  high in the cycle operands a/b/c/d are presented to the upstream pipeline.
REQ-007 SHALL have port pipe_out  in  DATA_W  result from the upstream pipeline, unsigned.
REQ-008 SHALL have port frame_ready  in  1  downstream accepts the frame summary.
REQ-009 SHALL have port frame_valid  out  1  frame summary valid.
REQ-010 SHALL have port sum_out  out  16  unsigned sum of the frame samples.
REQ-011 SHALL have port max_out  out  DATA_W  largest sample in the frame.
REQ-012 SHALL have port min_out  out  DATA_W  smallest sample in the frame.
REQ-013 SHALL have port drop_cnt  out  8  saturating count of samples discarded while a frame was pending.

Function
REQ-014 SHALL delay in_valid by exactly LAT cycles (s_valid) so that it aligns with the matching pipe_out.
REQ-015 SHALL treat a sample as present in a cycle where s_valid=1, with the data taken from pipe_out in that same cycle.
REQ-016 SHALL implement a state machine with states IDLE, ACCUM and DONE.
REQ-017 SHALL, in IDLE on a sample, load sum=sample, max=sample, min=sample, set count=1 and go to ACCUM.
REQ-018 SHALL, in ACCUM on a sample, perform sum+=sample (16-bit, no overflow possible in range), update max/min, and increment count.
REQ-019 SHALL go from ACCUM to DONE on the cycle the FRAME_LEN-th sample is absorbed.
REQ-020 SHALL assert frame_valid starting on the next cycle, so the summary appears 1 cycle after the last sample.
REQ-021 SHALL, in DONE, hold frame_valid=1 and sum_out/max_out/min_out stable until frame_ready=1.
REQ-022 SHALL complete the handshake on a cycle where frame_valid=1 and frame_ready=1.
REQ-023 SHALL, on handshake with no sample in the same cycle, deassert frame_valid next cycle and go to IDLE.
REQ-024 SHALL, on handshake with a sample in the same cycle, go to ACCUM with that sample as sample 1 of the new frame, so no loss occurs.
REQ-025 SHALL, on a sample in DONE without handshake, discard the sample and increment drop_cnt, saturating at 255.
REQ-026 SHALL keep sum_out/max_out/min_out at the last completed frame's values while not in DONE.
REQ-027 SHALL leave the state unchanged in IDLE or ACCUM when no sample is present, with no timeout.
REQ-028 SHALL hold equal max and min when all samples in a frame are equal.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, clear all LAT delay stages, set state=IDLE, count=0, frame_valid=0, sum_out=0, max_out=0, min_out=0 and drop_cnt=0.
REQ-030 SHALL discard a partially accumulated frame on reset mid-frame, and SHALL not count samples that were in flight in the delay line.
REQ-031 SHALL accept in_valid in the first cycle after rst deasserts, producing its sample LAT cycles later.

Structure
REQ-032 SHALL place the state enum (IDLE/ACCUM/DONE), the SUM_W=16 constant and the DROP_W=8 constant in shared package pipe_pkg.
REQ-033 SHALL implement the LAT-stage valid shift register as sub-module valid_delay, with parameter LAT and synchronous reset.

Verification
REQ-034 SHALL cover a basic frame: rst for 2 cycles, then in_valid for 4 consecutive cycles, with pipe_out driven LAT=3 cycles later as 10,20,5,40 and frame_ready=1 -> frame_valid for 1 cycle after the 4th sample with sum_out=75, max_out=40, min_out=5, drop_cnt=0.
REQ-035 SHALL cover backpressure: frame_ready=0, frame 4x255, then 2 extra samples -> sum_out=1020, max=min=255 held stable and drop_cnt=2; frame_ready=1 -> frame_valid falls next cycle.
REQ-036 SHALL cover the simultaneous case: handshake cycle coincides with sample value 7, followed by 3 samples of 1 -> no drop, and the next frame has sum_out=10, max_out=7, min_out=1.
REQ-037 SHALL cover reset mid-frame: 2 samples (50,60), rst pulse, then 4 samples of 3 -> sum_out=12, and the earlier samples are absent.
REQ-038 SHALL cover gaps: samples 1,2,3,4 separated by idle cycles -> sum_out=10, and frame_valid rises exactly 1 cycle after the 4th s_valid.
REQ-039 SHALL cover saturation: 300 samples dropped while in DONE -> drop_cnt=255.
